mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1023, is the number of WAIT cycles without a memory response before the block returns an error response.
REQ-002 clk  input  1  is the system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-004 ifu_req_valid  input  1  is the fetch read request.
REQ-005 ifu_addr  input  32  is the fetch address.
REQ-006 ifu_req_ready  output  1  indicates the fetch request is accepted this cycle.
REQ-007 ifu_rsp_valid  output  1  is a one-cycle pulse marking a fetch response.
REQ-008 ifu_rdata  output  32  is the fetched instruction word.
REQ-009 ifu_rsp_err  output  1  flags a fetch response as a timeout.
REQ-010 lsu_req_valid  input  1  is the load/store request.
REQ-011 lsu_addr  input  32  is the load/store address.
REQ-012 lsu_wen  input  1  selects write (1) or read (0).
REQ-013 lsu_wdata  input  32  is the store data.
REQ-014 lsu_wmask  input  4  holds the store byte enables.
REQ-015 lsu_req_ready  output  1  indicates the load/store request is accepted this cycle.
REQ-016 lsu_rsp_valid  output  1  is a one-cycle pulse marking a load/store response.
REQ-017 lsu_rdata  output  32  is the load data.
REQ-018 lsu_rsp_err  output  1  flags a load/store response as a timeout.
REQ-019 mem_req_valid, mem_addr[32], mem_wen, mem_wdata[32], mem_wmask[4]  outputs  carry the single shared memory request.
REQ-020 mem_req_ready  input  1  indicates the memory accepts the request.
REQ-021 mem_rsp_valid  input  1  marks a memory response; mem_rdata  input  32  carries its data.

Function
REQ-022 The FSM SHALL have three states:
- IDLE: no transaction.
- REQ: mem_req_valid=1, waiting for mem_req_ready.
- WAIT: waiting for mem_rsp_valid.
REQ-023 In IDLE, the block SHALL grant one valid requester per cycle.
- Grant: that requester's *_req_ready=1 combinationally, in the same cycle.
- Latched in the same cycle: owner, addr, wen, wdata, wmask.
- Next state: REQ.
REQ-024 Simultaneous requests in IDLE SHALL be resolved round-robin: the requester not granted most recently wins.
REQ-025 *_req_ready SHALL be 0 in REQ and WAIT, and 0 for the losing requester.
REQ-026 A fetch request SHALL drive mem_wen=0 and mem_wmask=0.
REQ-027 In REQ, mem_* SHALL hold the latched fields stable.
- mem_req_valid stays 1 until a cycle with mem_req_ready=1.
- In that cycle the block transitions to WAIT.
REQ-028 In WAIT, a cycle with mem_rsp_valid=1 SHALL cause, on the next cycle:
- the owner's *_rsp_valid=1 for exactly one cycle;
- *_rdata = the captured mem_rdata, with *_rsp_err=0;
- the FSM returns to IDLE, in the same edge.
REQ-029 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-030 Write responses SHALL pulse lsu_rsp_valid; lsu_rdata SHALL take the mem_rdata value.
REQ-031 The WAIT cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- When it reaches TIMEOUT without a response: owner *_rsp_valid=1, *_rsp_err=1, *_rdata=0, next cycle.
- The FSM returns to IDLE.
- A later mem_rsp_valid SHALL be ignored.
REQ-032 Minimum latency SHALL be 3 cycles from the accept cycle to the rsp_valid cycle (accept at T, mem handshake at T+1, mem_rsp at T+2, rsp_valid at T+3).
REQ-033 *_rdata and *_rsp_err SHALL hold their values after the pulse until the next response to the same requester.
REQ-034 The block SHALL accept a new grant in the cycle the FSM is back in IDLE, i.e. the same cycle as the previous rsp_valid pulse.

Reset
REQ-035 While reset=0, all of the following SHALL hold:
- state=IDLE;
- all outputs 0: *_req_ready, *_rsp_valid, *_rdata, *_rsp_err, mem_*;
- counter=0;
- last-grant=LSU, so IFU wins the first tie.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction, with no response pulse delivered afterwards.

Verification
REQ-037 Single fetch: ifu_req_valid, ifu_addr=0x80000000 at T; mem_req_ready=1 at T+1; mem_rsp_valid with mem_rdata=0x00000413 at T+2 -> ifu_req_ready=1 at T, mem_addr=0x80000000 at T+1, ifu_rsp_valid=1 with ifu_rdata=0x00000413 at T+3 only.
REQ-038 Tie after reset: both requests valid continuously, memory responding immediately -> grant order IFU, LSU, IFU, LSU; no requester is granted twice in a row.
REQ-039 Store: lsu_wen=1, lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF, lsu_wmask=0xF; mem_req_ready held 0 for 5 cycles -> mem_* stable for all 6 REQ cycles; lsu_rsp_valid pulses once after the response.
REQ-040 Timeout with TIMEOUT=4: memory never responds -> lsu_rsp_valid=1, lsu_rsp_err=1, lsu_rdata=0 after 4 WAIT cycles; a late mem_rsp_valid produces no pulse.
REQ-041 Reset mid-WAIT: reset=0 for 1 cycle while in WAIT, then mem_rsp_valid -> no rsp_valid pulse; the next tie is granted to IFU.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter onto a single memory port.
// Fetch (ifu_*) and load/store (lsu_*) requests share mem_*, one at a time.
// Ports: clk; reset (synchronous, active-low);
//   ifu_req_valid/ifu_addr/ifu_req_ready, ifu_rsp_valid/ifu_rdata/ifu_rsp_err;
//   lsu_req_valid/lsu_addr/lsu_wen/lsu_wdata/lsu_wmask/lsu_req_ready,
//   lsu_rsp_valid/lsu_rdata/lsu_rsp_err;
//   mem_req_valid/mem_addr/mem_wen/mem_wdata/mem_wmask/mem_req_ready,
//   mem_rsp_valid/mem_rdata.
// TIMEOUT: WAIT cycles without a memory response before an error response.
module mem_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ifu_req_valid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_req_ready,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_rsp_err,
   input  logic        lsu_req_valid,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_req_ready,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_rsp_err,
   output logic        mem_req_valid,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic          last_lsu_q;
   logic          owner_lsu_q;
   logic [31:0]   addr_q;
   logic          wen_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wmask_q;
   logic [CW-1:0] cnt_q;

   logic pick_ifu;
   logic rsp_hit;
   logic tmo;
   logic done;

   // IFU wins unless LSU is also asking and IFU had the last grant.
   assign pick_ifu = ifu_req_valid & (~lsu_req_valid | last_lsu_q);

   assign rsp_hit = (state_q == ST_WAIT) & mem_rsp_valid;
   assign tmo     = (state_q == ST_WAIT) & ~mem_rsp_valid
                  & (cnt_q == CNT_LAST);
   assign done    = rsp_hit | tmo;

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ifu_req_ready | lsu_req_ready) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Grants are combinational, so they must also be masked by reset.
   always_comb begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (reset) begin
               ifu_req_ready = pick_ifu;
               lsu_req_ready = lsu_req_valid & ~pick_ifu;
            end
         end
         ST_REQ: mem_req_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_lsu_q    <= 1'b1;
         owner_lsu_q   <= 1'b0;
         addr_q        <= '0;
         wen_q         <= 1'b0;
         wdata_q       <= '0;
         wmask_q       <= '0;
         cnt_q         <= '0;
         ifu_rsp_valid <= 1'b0;
         ifu_rdata     <= '0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rdata     <= '0;
         lsu_rsp_err   <= 1'b0;
      end else begin
         ifu_rsp_valid <= 1'b0;
         lsu_rsp_valid <= 1'b0;

         if (ifu_req_ready) begin
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            addr_q      <= ifu_addr;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
         end else if (lsu_req_ready) begin
            owner_lsu_q <= 1'b1;
            last_lsu_q  <= 1'b1;
            addr_q      <= lsu_addr;
            wen_q       <= lsu_wen;
            wdata_q     <= lsu_wdata;
            wmask_q     <= lsu_wmask;
         end

         if ((state_q == ST_REQ) && mem_req_ready) begin
            cnt_q <= '0;
         end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
         end

         // A timeout reports zero data; a real response reports mem_rdata.
         if (done) begin
            if (owner_lsu_q) begin
               lsu_rsp_valid <= 1'b1;
               lsu_rdata     <= rsp_hit ? mem_rdata : '0;
               lsu_rsp_err   <= tmo;
            end else begin
               ifu_rsp_valid <= 1'b1;
               ifu_rdata     <= rsp_hit ? mem_rdata : '0;
               ifu_rsp_err   <= tmo;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand sequences and a randomized
// run against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int TMO = 4;

   logic        clk;
   logic        reset;
   logic        ifu_req_valid;
   logic [31:0] ifu_addr;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rdata;
   logic        ifu_rsp_err;
   logic        lsu_req_valid;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_req_ready;
   logic        lsu_rsp_valid;
   logic [31:0] lsu_rdata;
   logic        lsu_rsp_err;
   logic        mem_req_valid;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;

   int checks;
   int failures;

   mem_arbiter #(.TIMEOUT(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .ifu_req_valid (ifu_req_valid),
      .ifu_addr      (ifu_addr),
      .ifu_req_ready (ifu_req_ready),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rdata     (ifu_rdata),
      .ifu_rsp_err   (ifu_rsp_err),
      .lsu_req_valid (lsu_req_valid),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_req_ready (lsu_req_ready),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rdata     (lsu_rdata),
      .lsu_rsp_err   (lsu_rsp_err),
      .mem_req_valid (mem_req_valid),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ifu_v;
      logic [31:0] ifu_a;
      logic        lsu_v;
      logic [31:0] lsu_a;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          rdy_dly;
      int          rsp_dly;
      logic [31:0] mrdata;
      logic        exp_lsu;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic        lsu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } txn_t;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ifu_req_valid = 1'b0;
      ifu_addr      = '0;
      lsu_req_valid = 1'b0;
      lsu_addr      = '0;
      lsu_wen       = 1'b0;
      lsu_wdata     = '0;
      lsu_wmask     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] ea;
      logic        ew;
      logic [3:0]  em;
      int          nw;
      ea = v.exp_lsu ? v.lsu_a : v.ifu_a;
      ew = v.exp_lsu ? v.wen : 1'b0;
      em = v.exp_lsu ? v.wmask : 4'h0;
      ifu_req_valid = v.ifu_v;
      ifu_addr      = v.ifu_a;
      lsu_req_valid = v.lsu_v;
      lsu_addr      = v.lsu_a;
      lsu_wen       = v.wen;
      lsu_wdata     = v.wdata;
      lsu_wmask     = v.wmask;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = v.mrdata;
      #1;
      chk1("grant_ifu", ifu_req_ready, ~v.exp_lsu);
      chk1("grant_lsu", lsu_req_ready, v.exp_lsu);
      for (int i = 0; i <= v.rdy_dly; i++) begin
         tick();
         mem_req_ready = (i == v.rdy_dly);
         #1;
         chk1("req_valid", mem_req_valid, 1'b1);
         chk32("req_addr", mem_addr, ea);
         chk1("req_wen", mem_wen, ew);
         chk32("req_wmask", {28'h0, mem_wmask}, {28'h0, em});
         if (v.exp_lsu) chk32("req_wdata", mem_wdata, v.wdata);
         chk1("busy_noready", ifu_req_ready | lsu_req_ready, 1'b0);
      end
      nw = (v.rsp_dly < TMO) ? v.rsp_dly + 1 : TMO;
      for (int k = 0; k < nw; k++) begin
         tick();
         mem_req_ready = 1'b0;
         mem_rsp_valid = (k == v.rsp_dly);
         #1;
         chk1("wait_quiet", mem_req_valid | ifu_rsp_valid | lsu_rsp_valid
              | ifu_req_ready | lsu_req_ready, 1'b0);
      end
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_rsp_valid = 1'b1;
      #1;
      chk1("pulse_ifu", ifu_rsp_valid, ~v.exp_lsu);
      chk1("pulse_lsu", lsu_rsp_valid, v.exp_lsu);
      chk32("rsp_rdata", v.exp_lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
      chk1("rsp_err", v.exp_lsu ? lsu_rsp_err : ifu_rsp_err, v.exp_err);
      for (int k = 0; k < 2; k++) begin
         tick();
         mem_rsp_valid = (k == 0);
         #1;
         chk1("one_pulse", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
         chk32("rdata_hold", v.exp_lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
         chk1("err_hold", v.exp_lsu ? lsu_rsp_err : ifu_rsp_err, v.exp_err);
      end
   endtask

   task automatic run_random(input int ncyc);
      logic        busy, last_lsu, phase_req, ifu_pend, lsu_pend;
      logic        ifu_acc, lsu_acc, m_pend, pulse, gi, gl;
      int          rsp_due, m_fire, d;
      logic [31:0] m_data, cur_rdata, e_ird, e_lrd;
      logic        cur_err, e_ierr, e_lerr;
      txn_t        cur;
      busy = 0; last_lsu = 1; phase_req = 0; ifu_pend = 0; lsu_pend = 0;
      ifu_acc = 0; lsu_acc = 0; m_pend = 0;
      rsp_due = -1; m_fire = -1; m_data = '0;
      cur_rdata = '0; cur_err = 0;
      e_ird = '0; e_lrd = '0; e_ierr = 0; e_lerr = 0;
      cur = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
      for (int c = 0; c < ncyc; c++) begin
         tick();
         pulse = (rsp_due == c);
         if (pulse) begin
            busy = 0;
            rsp_due = -1;
            if (cur.lsu) begin
               e_lrd = cur_rdata;
               e_lerr = cur_err;
            end else begin
               e_ird = cur_rdata;
               e_ierr = cur_err;
            end
         end
         chk1("rnd_ifu_pulse", ifu_rsp_valid, pulse & ~cur.lsu);
         chk1("rnd_lsu_pulse", lsu_rsp_valid, pulse & cur.lsu);
         chk32("rnd_ifu_rdata", ifu_rdata, e_ird);
         chk32("rnd_lsu_rdata", lsu_rdata, e_lrd);
         chk1("rnd_ifu_err", ifu_rsp_err, e_ierr);
         chk1("rnd_lsu_err", lsu_rsp_err, e_lerr);

         if (ifu_acc) ifu_pend = 0;
         if (lsu_acc) lsu_pend = 0;
         if (!ifu_pend && $urandom_range(0, 99) < 40) begin
            ifu_pend = 1;
            ifu_addr = $urandom;
         end
         if (!lsu_pend && $urandom_range(0, 99) < 40) begin
            lsu_pend  = 1;
            lsu_addr  = $urandom;
            lsu_wen   = 1'($urandom_range(0, 1));
            lsu_wdata = $urandom;
            lsu_wmask = 4'($urandom_range(0, 15));
         end
         ifu_req_valid = ifu_pend;
         lsu_req_valid = lsu_pend;
         if (m_pend && m_fire == c) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = m_data;
            m_pend = 0;
         end else begin
            // Stray responses only while no real one is outstanding.
            mem_rsp_valid = ~m_pend & ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
         end
         mem_req_ready = ~m_pend & 1'($urandom_range(0, 1));
         #1;

         gi = ~busy & ifu_pend & (~lsu_pend | last_lsu);
         gl = ~busy & lsu_pend & ~gi;
         chk1("rnd_ifu_ready", ifu_req_ready, gi);
         chk1("rnd_lsu_ready", lsu_req_ready, gl);
         chk1("rnd_mem_valid", mem_req_valid, phase_req);
         if (phase_req) begin
            chk32("rnd_mem_addr", mem_addr, cur.addr);
            chk1("rnd_mem_wen", mem_wen, cur.wen);
            chk32("rnd_mem_wmask", {28'h0, mem_wmask}, {28'h0, cur.wmask});
            if (cur.lsu) chk32("rnd_mem_wdata", mem_wdata, cur.wdata);
         end

         ifu_acc = gi;
         lsu_acc = gl;
         if (phase_req && mem_req_ready) begin
            phase_req = 0;
            d = $urandom_range(0, 5);
            m_data = $urandom;
            m_fire = c + 1 + d;
            m_pend = 1;
            if (d < TMO) begin
               rsp_due = c + 2 + d;
               cur_rdata = m_data;
               cur_err = 0;
            end else begin
               rsp_due = c + 1 + TMO;
               cur_rdata = '0;
               cur_err = 1;
            end
         end
         if (gi || gl) begin
            busy = 1;
            phase_req = 1;
            last_lsu = gl;
            cur.lsu   = gl;
            cur.addr  = gl ? lsu_addr : ifu_addr;
            cur.wen   = gl ? lsu_wen : 1'b0;
            cur.wdata = lsu_wdata;
            cur.wmask = gl ? lsu_wmask : 4'h0;
         end
      end
      idle_inputs();
   endtask

   vec_t vt[8];

   initial begin
      checks = 0;
      failures = 0;
      vt[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                0, 0, 32'h0000_0413, 1'b0, 32'h0000_0413, 1'b0};
      vt[1] = '{1'b1, 32'h8000_0004, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0,
                1, 1, 32'h1111_1111, 1'b1, 32'h1111_1111, 1'b0};
      vt[2] = '{1'b1, 32'h8000_0008, 1'b1, 32'h8000_2004, 1'b1, 32'hCAFE_F00D,
                4'hF, 0, 2, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0};
      vt[3] = '{1'b1, 32'h8000_000C, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF,
                4'hF, 5, 1, 32'h3333_3333, 1'b1, 32'h3333_3333, 1'b0};
      vt[4] = '{1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0,
                2, 3, 32'h4444_4444, 1'b0, 32'h4444_4444, 1'b0};
      vt[5] = '{1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0,
                0, 7, 32'h9999_9999, 1'b1, 32'h0, 1'b1};
      vt[6] = '{1'b1, 32'h8000_0014, 1'b1, 32'h8000_3004, 1'b0, 32'h0, 4'h0,
                1, 9, 32'h8888_8888, 1'b0, 32'h0, 1'b1};
      vt[7] = '{1'b0, 32'h0, 1'b1, 32'h8000_3008, 1'b1, 32'h0102_0304, 4'h3,
                0, 2, 32'h5555_5555, 1'b1, 32'h5555_5555, 1'b0};

      idle_inputs();
      reset = 1'b0;
      tick();
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      mem_rsp_valid = 1'b1;
      #1;
      chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
      chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
      chk1("rst_mem_valid", mem_req_valid, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_rsp_valid", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
      chk32("rst_ifu_rdata", ifu_rdata, 32'h0);
      chk32("rst_lsu_rdata", lsu_rdata, 32'h0);
      chk1("rst_err", ifu_rsp_err | lsu_rsp_err, 1'b0);

      do_reset();
      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      do_reset();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0100;
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_0200;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'h7777_7777;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) tick();
         #1;
         chk1("rr_ifu_ready", ifu_req_ready,
              (c % 3 == 0) && ((c / 3) % 2 == 0));
         chk1("rr_lsu_ready", lsu_req_ready,
              (c % 3 == 0) && ((c / 3) % 2 == 1));
         chk1("rr_ifu_pulse", ifu_rsp_valid,
              (c % 3 == 0) && (c > 0) && ((c / 3) % 2 == 1));
         chk1("rr_lsu_pulse", lsu_rsp_valid,
              (c % 3 == 0) && (c > 0) && ((c / 3) % 2 == 0));
      end

      do_reset();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      #1;
      chk1("rw_grant", ifu_req_ready, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk1("rw_in_wait", mem_req_valid, 1'b0);
      reset = 1'b0;
      tick();
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      chk1("rw_rst_ready", ifu_req_ready | lsu_req_ready, 1'b0);
      chk32("rw_rst_addr", mem_addr, 32'h0);
      chk1("rw_rst_pulse", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
      reset = 1'b1;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      for (int k = 0; k < 3; k++) begin
         tick();
         mem_rsp_valid = 1'b0;
         #1;
         chk1("rw_no_pulse", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
      end
      chk32("rw_rdata_clr", ifu_rdata, 32'h0);
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      #1;
      chk1("rw_tie_ifu", ifu_req_ready, 1'b1);
      chk1("rw_tie_lsu", lsu_req_ready, 1'b0);

      do_reset();
      run_random(4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
